// File: rtl/joystick_reader.sv
// PmodJSTK poller: periodically runs a 5-byte SPI mode-0 transaction and
// publishes quantized X, raw Y and button state in one update per poll.
module joystick_reader #(
    parameter int unsigned CLK_DIV     = 25,
    parameter int unsigned SS_WAIT     = 750,
    parameter int unsigned BYTE_GAP    = 500,
    parameter int unsigned POLL_CYCLES = 500000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] Led,
    input  logic       MISO,
    output logic       SS,
    output logic       SCLK,
    output logic       MOSI,
    output logic [3:0] Joystick_data,
    output logic [9:0] Joystick_Y,
    output logic [2:0] Buttons,
    output logic       Data_Valid
);

    localparam int unsigned MAX_A   = (CLK_DIV > SS_WAIT) ? CLK_DIV : SS_WAIT;
    localparam int unsigned MAX_B   = (BYTE_GAP > POLL_CYCLES) ? BYTE_GAP : POLL_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       half, half_nxt;
    logic [2:0]       byte_idx, byte_nxt;
    logic [7:0]       tx, tx_nxt;
    logic [7:0]       rx, rx_nxt;
    logic [9:0]       x_raw, x_nxt;
    logic [9:0]       y_raw, y_nxt;
    logic [2:0]       btn_raw, btn_nxt;

    logic             ss_d, sclk_d, mosi_d, dv_d;
    logic [3:0]       x_hi;
    logic [3:0]       jd_d;

    // State, datapath and output registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            cnt           <= '0;
            half          <= '0;
            byte_idx      <= '0;
            tx            <= '0;
            rx            <= '0;
            x_raw         <= '0;
            y_raw         <= '0;
            btn_raw       <= '0;
            SS            <= 1'b1;
            SCLK          <= 1'b0;
            MOSI          <= 1'b0;
            Data_Valid    <= 1'b0;
            Joystick_data <= 4'd5;
            Joystick_Y    <= 10'd512;
            Buttons       <= 3'b000;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            half       <= half_nxt;
            byte_idx   <= byte_nxt;
            tx         <= tx_nxt;
            rx         <= rx_nxt;
            x_raw      <= x_nxt;
            y_raw      <= y_nxt;
            btn_raw    <= btn_nxt;
            SS         <= ss_d;
            SCLK       <= sclk_d;
            MOSI       <= mosi_d;
            Data_Valid <= dv_d;
            if (dv_d) begin
                Joystick_data <= jd_d;
                Joystick_Y    <= y_nxt;
                Buttons       <= btn_nxt;
            end
        end
    end

    // Next state: SCLK starts high on SHIFT entry, so even halves are high
    // phases (MISO sampled on entry) and odd halves low (MOSI shifts on entry).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        half_nxt  = half;
        byte_nxt  = byte_idx;
        tx_nxt    = tx;
        rx_nxt    = rx;
        x_nxt     = x_raw;
        y_nxt     = y_raw;
        btn_nxt   = btn_raw;
        case (state)
            IDLE: begin
                if (cnt == CNT_W'(POLL_CYCLES - 1)) begin
                    state_nxt = SETUP;
                    cnt_nxt   = '0;
                    byte_nxt  = '0;
                    tx_nxt    = {6'b100000, Led};
                end
            end
            SETUP: begin
                if (cnt == CNT_W'(SS_WAIT - 1)) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    half_nxt  = '0;
                    rx_nxt    = {rx[6:0], MISO};
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(CLK_DIV - 1)) begin
                    cnt_nxt  = '0;
                    half_nxt = half + 4'd1;
                    if (!half[0]) begin
                        tx_nxt = {tx[6:0], 1'b0};
                    end else if (half != 4'd15) begin
                        rx_nxt = {rx[6:0], MISO};
                    end
                    if (half == 4'd15) begin
                        case (byte_idx)
                            3'd0:    x_nxt[7:0] = rx;
                            3'd1:    x_nxt[9:8] = rx[1:0];
                            3'd2:    y_nxt[7:0] = rx;
                            3'd3:    y_nxt[9:8] = rx[1:0];
                            default: btn_nxt    = rx[2:0];
                        endcase
                        if (byte_idx == 3'd4) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt = GAP;
                            byte_nxt  = byte_idx + 3'd1;
                            tx_nxt    = 8'h00;
                        end
                    end
                end
            end
            GAP: begin
                if (cnt == CNT_W'(BYTE_GAP - 1)) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    half_nxt  = '0;
                    rx_nxt    = {rx[6:0], MISO};
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so the pins are registered
    always_comb begin
        ss_d   = 1'b1;
        sclk_d = 1'b0;
        mosi_d = tx_nxt[7];
        dv_d   = 1'b0;
        x_hi   = x_nxt[9:6];
        jd_d   = (x_hi < 4'd3) ? 4'd0 : x_hi - 4'd3;
        case (state_nxt)
            SETUP, GAP: ss_d = 1'b0;
            SHIFT: begin
                ss_d   = 1'b0;
                sclk_d = !half_nxt[0];
            end
            DONE:    dv_d = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_joystick_reader.sv
// Directed bench for joystick_reader: table of polls against an SPI slave
// model, with edge-timing monitor and a mid-transaction reset sequence.
module tb_joystick_reader;

    localparam int unsigned CD   = 2;
    localparam int unsigned SSW  = 6;
    localparam int unsigned BG   = 5;
    localparam int unsigned POLL = 40;

    logic       Clk;
    logic       Reset;
    logic [1:0] Led;
    logic       MISO;
    logic       SS, SCLK, MOSI;
    logic [3:0] Joystick_data;
    logic [9:0] Joystick_Y;
    logic [2:0] Buttons;
    logic       Data_Valid;

    joystick_reader #(
        .CLK_DIV(CD), .SS_WAIT(SSW), .BYTE_GAP(BG), .POLL_CYCLES(POLL)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Led(Led), .MISO(MISO),
        .SS(SS), .SCLK(SCLK), .MOSI(MOSI),
        .Joystick_data(Joystick_data), .Joystick_Y(Joystick_Y),
        .Buttons(Buttons), .Data_Valid(Data_Valid)
    );

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] btn;
        logic [1:0] led;
        logic [3:0] jd;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [39:0] frame    = '0;
    logic [39:0] sh_miso  = '0;
    logic [39:0] mosi_cap = '0;
    logic [39:0] exp_mosi = '0;
    bit          tim_en   = 0;
    bit          have_dv  = 0;
    int          rises = 0, last_rise = 0, ss_fall_cyc = 0, dv_cyc = 0;
    int          dv_count = 0, glitch = 0;
    bit          prev_ss = 1, prev_sclk = 0, prev_dv = 0, prev_rst = 1;
    logic [16:0] prev_out = '0;

    assign MISO = sh_miso[39];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [39:0] mk_frame(input vec_t v);
        return {v.x[7:0], 6'b101010, v.x[9:8], v.y[7:0], 6'b010101, v.y[9:8], 5'b11011, v.btn};
    endfunction

    // SPI slave model plus SCLK/SS timing and output-stability monitor
    always @(negedge Clk) begin
        if (Reset) begin
            have_dv = 0;
        end else begin
            if (prev_ss && !SS) begin
                ss_fall_cyc = cyc;
                rises       = 0;
                mosi_cap    = '0;
                sh_miso     = frame;
                if (tim_en && have_dv) check("poll_gap", 64'(cyc - dv_cyc), 64'(POLL + 1));
            end
            if (!prev_sclk && SCLK) begin
                if (tim_en) begin
                    if (rises == 0) check("ss_to_first_rise", 64'(cyc - ss_fall_cyc), 64'(SSW));
                    else if (rises % 8 == 0) check("byte_gap_period", 64'(cyc - last_rise), 64'(2 * CD + BG));
                    else check("bit_period", 64'(cyc - last_rise), 64'(2 * CD));
                end
                rises++;
                last_rise = cyc;
                mosi_cap  = {mosi_cap[38:0], MOSI};
            end
            if (prev_sclk && !SCLK) begin
                if (tim_en) check("sclk_high", 64'(cyc - last_rise), 64'(CD));
                if (!SS) sh_miso = sh_miso << 1;
            end
            if (Data_Valid) begin
                dv_count++;
                dv_cyc  = cyc;
                have_dv = 1;
                if (tim_en) begin
                    check("dv_one_cycle", 64'(prev_dv), 64'(0));
                    check("ss_high_at_done", 64'(SS), 64'(1));
                    check("rises_per_txn", 64'(rises), 64'(40));
                    check("mosi_frame", 64'(mosi_cap), 64'(exp_mosi));
                end
            end else if (!prev_rst && ({Joystick_data, Joystick_Y, Buttons} != prev_out)) begin
                glitch++;
            end
        end
        prev_ss   = SS;
        prev_sclk = SCLK;
        prev_dv   = Data_Valid;
        prev_rst  = Reset;
        prev_out  = {Joystick_data, Joystick_Y, Buttons};
    end

    task automatic wait_ss_fall(output bit ok);
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge Clk); #1;
            if (!SS) begin ok = 1; break; end
        end
    endtask

    task automatic wait_dv(output bit ok);
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge Clk); #1;
            if (Data_Valid) begin ok = 1; break; end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ss"},   64'(SS), 64'(1));
        check({tag, "_sclk"}, 64'(SCLK), 64'(0));
        check({tag, "_mosi"}, 64'(MOSI), 64'(0));
        check({tag, "_jd"},   64'(Joystick_data), 64'(5));
        check({tag, "_y"},    64'(Joystick_Y), 64'(512));
        check({tag, "_btn"},  64'(Buttons), 64'(0));
        check({tag, "_dv"},   64'(Data_Valid), 64'(0));
    endtask

    vec_t vecs [7];
    vec_t rv;
    bit   ok;
    int   c0, dvb;

    initial begin
        vecs[0] = '{x: 10'd512,  y: 10'd300,  btn: 3'b010, led: 2'b11, jd: 4'd5};
        vecs[1] = '{x: 10'd1023, y: 10'd1023, btn: 3'b111, led: 2'b01, jd: 4'd12};
        vecs[2] = '{x: 10'd0,    y: 10'd0,    btn: 3'b000, led: 2'b10, jd: 4'd0};
        vecs[3] = '{x: 10'd191,  y: 10'd5,    btn: 3'b100, led: 2'b00, jd: 4'd0};
        vecs[4] = '{x: 10'd192,  y: 10'd700,  btn: 3'b001, led: 2'b11, jd: 4'd0};
        vecs[5] = '{x: 10'd256,  y: 10'd513,  btn: 3'b011, led: 2'b01, jd: 4'd1};
        vecs[6] = '{x: 10'd700,  y: 10'd64,   btn: 3'b101, led: 2'b10, jd: 4'd7};
        rv      = '{x: 10'd900,  y: 10'd77,   btn: 3'b110, led: 2'b01, jd: 4'd11};

        Reset = 1'b1;
        Led   = 2'b00;
        repeat (3) @(negedge Clk);
        #1;
        check_reset_outputs("reset");

        @(negedge Clk); #1;
        Reset  = 1'b0;
        c0     = cyc;
        tim_en = 1;

        // Back-to-back polls; Led flips after SS falls and must not reach MOSI
        for (int i = 0; i < 7; i++) begin
            frame    = mk_frame(vecs[i]);
            Led      = vecs[i].led;
            exp_mosi = {6'b100000, vecs[i].led, 32'h0};
            wait_ss_fall(ok);
            check($sformatf("ss_fall_timeout_%0d", i), 64'(ok), 64'(1));
            if (i == 0) check("poll_after_reset", 64'(ss_fall_cyc - c0), 64'(POLL));
            repeat (5) @(negedge Clk);
            Led = ~Led;
            wait_dv(ok);
            check($sformatf("dv_timeout_%0d", i), 64'(ok), 64'(1));
            check($sformatf("jd_%0d", i),  64'(Joystick_data), 64'(vecs[i].jd));
            check($sformatf("y_%0d", i),   64'(Joystick_Y), 64'(vecs[i].y));
            check($sformatf("btn_%0d", i), 64'(Buttons), 64'(vecs[i].btn));
        end

        // Reset during byte 2 while SCLK is high
        frame    = mk_frame(rv);
        Led      = rv.led;
        exp_mosi = {6'b100000, rv.led, 32'h0};
        wait_ss_fall(ok);
        check("rst_ss_fall_timeout", 64'(ok), 64'(1));
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge Clk); #1;
            if (rises >= 18 && SCLK) begin ok = 1; break; end
        end
        check("rst_byte2_timeout", 64'(ok), 64'(1));
        tim_en = 0;
        dvb    = dv_count;
        Reset  = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge Clk);
        #1;
        Reset  = 1'b0;
        c0     = cyc;
        tim_en = 1;
        wait_ss_fall(ok);
        check("post_rst_ss_timeout", 64'(ok), 64'(1));
        check("poll_after_midrst", 64'(ss_fall_cyc - c0), 64'(POLL));
        check("no_dv_from_aborted", 64'(dv_count), 64'(dvb));
        wait_dv(ok);
        check("post_rst_dv_timeout", 64'(ok), 64'(1));
        check("post_rst_jd",  64'(Joystick_data), 64'(rv.jd));
        check("post_rst_y",   64'(Joystick_Y), 64'(rv.y));
        check("post_rst_btn", 64'(Buttons), 64'(rv.btn));
        @(negedge Clk); #1;
        check("post_rst_dv_count", 64'(dv_count), 64'(dvb + 1));
        check("outputs_stable_between_done", 64'(glitch), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
